// File: rtl/adc_bus_pkg.sv
// adc_bus_pkg -- shared definitions for the ADC I2C bus.
//
// Holds the I2C master instruction encoding (used by the master, the arbiter and
// every ADC user) and the arbiter state encoding, plus a small helper that turns a
// one-hot grant into an owner index.
package adc_bus_pkg;

  // I2C master instruction encoding.
  localparam logic [1:0] INST_START = 2'd0;
  localparam logic [1:0] INST_STOP  = 2'd1;
  localparam logic [1:0] INST_READ  = 2'd2;
  localparam logic [1:0] INST_WRITE = 2'd3;

  // Arbiter FSM state encoding.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StBusy    = 2'd1,
    StRelease = 2'd2
  } arb_state_e;

  // Owner index of a one-hot two-requester grant (01 -> 0, 10 -> 1).
  function automatic logic owner_idx(input logic [1:0] grant);
    return grant[1];
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2 -- two-way round-robin picker.
//
// Ports:
//   req_i   [1:0]  request vector, bit N = requester N
//   last_i         index of the requester granted most recently
//   gnt_o   [1:0]  one-hot winner, 00 when nobody requests
//
// A lone request always wins; on a tie the requester that was not granted last wins.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/adc_bus_arbiter.sv
// adc_bus_arbiter -- shares one I2C master between two requesters.
//
// Parameters:
//   TIMEOUT_CYCLES  max BUSY cycles without a master completion before forced release
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   reqN_instruction_i/enable_i/byte_to_send_i   requester N command (N=0,1)
//   reqN_byte_received_o/complete_o   response returned to requester N
//   i2c_instruction_o/enable_o/byte_to_send_o    command to the shared master
//   i2c_byte_received_i/complete_i    response from the shared master
//   grant_o                           one-hot owner, 00 = bus free
//   timeout_o                         one-cycle pulse on forced release
//
// Build option: define ADC_ARB_TIMEOUT_EN to add the BUSY watchdog. Without it the
// grant is held until the owner issues STOP and timeout_o is tied low.
//
// The grant is taken in IDLE, held for a whole START..STOP transaction, and only
// dropped once the owner lowers its enable after the STOP completes, so a lingering
// enable cannot be mistaken for a new transaction.
module adc_bus_arbiter
  import adc_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       clk_i,
  input  logic       rst_i,

  input  logic [1:0] req0_instruction_i,
  input  logic       req0_enable_i,
  input  logic [7:0] req0_byte_to_send_i,
  output logic [7:0] req0_byte_received_o,
  output logic       req0_complete_o,

  input  logic [1:0] req1_instruction_i,
  input  logic       req1_enable_i,
  input  logic [7:0] req1_byte_to_send_i,
  output logic [7:0] req1_byte_received_o,
  output logic       req1_complete_o,

  output logic [1:0] i2c_instruction_o,
  output logic       i2c_enable_o,
  output logic [7:0] i2c_byte_to_send_o,
  input  logic [7:0] i2c_byte_received_i,
  input  logic       i2c_complete_i,

  output logic [1:0] grant_o,
  output logic       timeout_o
);

  arb_state_e state_q;
  logic [1:0] grant_q;
  logic       last_q;
  logic [1:0] pick;

  // Command of whichever requester currently holds the grant.
  logic [1:0] gnt_inst;
  logic       gnt_en;
  logic [7:0] gnt_byte;

`ifdef ADC_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Counter holds (BUSY cycles so far - 1); hitting this ends the TIMEOUT_CYCLES-th cycle.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q;
  logic            timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  rr_pick2 u_pick (
    .req_i  ({req1_enable_i, req0_enable_i}),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  always_comb begin
    gnt_inst = 2'd0;
    gnt_en   = 1'b0;
    gnt_byte = 8'd0;
    unique case (grant_q)
      2'b01: begin
        gnt_inst = req0_instruction_i;
        gnt_en   = req0_enable_i;
        gnt_byte = req0_byte_to_send_i;
      end
      2'b10: begin
        gnt_inst = req1_instruction_i;
        gnt_en   = req1_enable_i;
        gnt_byte = req1_byte_to_send_i;
      end
      default: ;
    endcase
  end

  // Master sees the owner's command only while BUSY; zeros otherwise.
  always_comb begin
    i2c_instruction_o  = 2'd0;
    i2c_enable_o       = 1'b0;
    i2c_byte_to_send_o = 8'd0;
    if (state_q == StBusy) begin
      i2c_instruction_o  = gnt_inst;
      i2c_enable_o       = gnt_en;
      i2c_byte_to_send_o = gnt_byte;
    end
  end

  assign req0_complete_o      = i2c_complete_i & grant_q[0];
  assign req1_complete_o      = i2c_complete_i & grant_q[1];
  assign req0_byte_received_o = i2c_byte_received_i;
  assign req1_byte_received_o = i2c_byte_received_i;
  assign grant_o              = grant_q;

`ifdef ADC_ARB_TIMEOUT_EN
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      grant_q   <= 2'b00;
      last_q    <= 1'b1;
`ifdef ADC_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef ADC_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
`ifdef ADC_ARB_TIMEOUT_EN
          cnt_q <= '0;
`endif
          if (pick != 2'b00) begin
            grant_q <= pick;
            state_q <= StBusy;
          end
        end

        StBusy: begin
          if (i2c_complete_i && (gnt_inst == INST_STOP)) begin
            state_q <= StRelease;
          end
`ifdef ADC_ARB_TIMEOUT_EN
          else if (!i2c_complete_i && (cnt_q == CntLast)) begin
            // Master stalled: drop the bus straight to IDLE, as after a normal release.
            state_q   <= StIdle;
            grant_q   <= 2'b00;
            last_q    <= owner_idx(grant_q);
            timeout_q <= 1'b1;
          end
          // Any completion proves the master is alive.
          if (i2c_complete_i) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end

        StRelease: begin
          if (!gnt_en) begin
            grant_q <= 2'b00;
            last_q  <= owner_idx(grant_q);
            state_q <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_bus_arbiter.sv
// tb_adc_bus_arbiter -- scoreboard bench for adc_bus_arbiter.
//
// The driver applies one directed vector per cycle just after the rising edge and
// pushes that cycle's hand-computed expected outputs; the monitor pops one entry on
// every falling edge and compares it with what the DUT presents.
// Build with ADC_ARB_TIMEOUT_EN to exercise the watchdog (TIMEOUT_CYCLES = 16).
module tb_adc_bus_arbiter;
  import adc_bus_pkg::*;

  localparam int unsigned TbTimeout = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] r0_inst = '0, r1_inst = '0;
  logic       r0_en = 1'b0, r1_en = 1'b0;
  logic [7:0] r0_byte = '0, r1_byte = '0;
  logic [7:0] r0_rx, r1_rx;
  logic       r0_cmp, r1_cmp;
  logic [1:0] m_inst;
  logic       m_en;
  logic [7:0] m_byte;
  logic [7:0] m_rx = '0;
  logic       m_cmp = 1'b0;
  logic [1:0] grant;
  logic       tmo;

  always #5 clk = ~clk;

  adc_bus_arbiter #(
    .TIMEOUT_CYCLES (TbTimeout)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .req0_instruction_i   (r0_inst),
    .req0_enable_i        (r0_en),
    .req0_byte_to_send_i  (r0_byte),
    .req0_byte_received_o (r0_rx),
    .req0_complete_o      (r0_cmp),
    .req1_instruction_i   (r1_inst),
    .req1_enable_i        (r1_en),
    .req1_byte_to_send_i  (r1_byte),
    .req1_byte_received_o (r1_rx),
    .req1_complete_o      (r1_cmp),
    .i2c_instruction_o    (m_inst),
    .i2c_enable_o         (m_en),
    .i2c_byte_to_send_o   (m_byte),
    .i2c_byte_received_i  (m_rx),
    .i2c_complete_i       (m_cmp),
    .grant_o              (grant),
    .timeout_o            (tmo)
  );

  typedef struct packed {
    logic [1:0] gnt;
    logic       en;
    logic [1:0] inst;
    logic [7:0] byt;
    logic       c0;
    logic       c1;
    logic [7:0] rx0;
    logic [7:0] rx1;
    logic       tmo;
  } obs_t;

  typedef struct {
    bit    chk;
    string tag;
    obs_t  exp;
  } sb_t;

  sb_t sb_q[$];
  int  total = 0;
  int  bad   = 0;
  int  n_cyc = 0;

  // Monitor: one scoreboard entry per presented cycle.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      sb_t  e;
      obs_t act;
      e   = sb_q.pop_front();
      act = '{gnt: grant, en: m_en, inst: m_inst, byt: m_byte, c0: r0_cmp, c1: r1_cmp,
              rx0: r0_rx, rx1: r1_rx, tmo: tmo};
      if (e.chk) begin
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s: got gnt=%b en=%b inst=%0d byte=%h c0=%b c1=%b rx=%h/%h tmo=%b, want gnt=%b en=%b inst=%0d byte=%h c0=%b c1=%b rx=%h/%h tmo=%b",
                   e.tag, act.gnt, act.en, act.inst, act.byt, act.c0, act.c1, act.rx0,
                   act.rx1, act.tmo, e.exp.gnt, e.exp.en, e.exp.inst, e.exp.byt, e.exp.c0,
                   e.exp.c1, e.exp.rx0, e.exp.rx1, e.exp.tmo);
        end
      end
    end
  end

  // Driver: apply one vector for the coming cycle and queue its expected outputs.
  task automatic cyc(input string tag, input bit chk, input logic r,
                     input logic e0, input logic [1:0] i0, input logic [7:0] d0,
                     input logic e1, input logic [1:0] i1, input logic [7:0] d1,
                     input logic cmp,
                     input logic [1:0] xg, input logic xen, input logic [1:0] xi,
                     input logic [7:0] xb, input logic xc0, input logic xc1,
                     input logic xt);
    sb_t        e;
    logic [7:0] rx;
    @(posedge clk);
    #1;
    n_cyc++;
    rx      = 8'hA0 ^ n_cyc[7:0];
    rst     = r;
    r0_en   = e0;
    r0_inst = i0;
    r0_byte = d0;
    r1_en   = e1;
    r1_inst = i1;
    r1_byte = d1;
    m_cmp   = cmp;
    m_rx    = rx;
    e.chk   = chk;
    e.tag   = tag;
    e.exp   = '{gnt: xg, en: xen, inst: xi, byt: xb, c0: xc0, c1: xc1,
                rx0: rx, rx1: rx, tmo: xt};
    sb_q.push_back(e);
  endtask

  initial begin
    // Req0 alone: START, WRITE 0x90, STOP, then release on enable drop.
    cyc("rst",         0, 1, 0, INST_START, 8'h00, 0, INST_START, 8'h00, 0, 2'b00, 0, 2'd0, 8'h00, 0, 0, 0);
    cyc("a_idle",      1, 0, 0, INST_START, 8'h00, 0, INST_START, 8'h00, 0, 2'b00, 0, 2'd0, 8'h00, 0, 0, 0);
    cyc("a_req",       1, 0, 1, INST_START, 8'h00, 0, INST_START, 8'h00, 0, 2'b00, 0, 2'd0, 8'h00, 0, 0, 0);
    cyc("a_start",     1, 0, 1, INST_START, 8'h00, 0, INST_START, 8'h00, 0, 2'b01, 1, INST_START, 8'h00, 0, 0, 0);
    cyc("a_start_cmp", 1, 0, 1, INST_START, 8'h00, 0, INST_START, 8'h00, 1, 2'b01, 1, INST_START, 8'h00, 1, 0, 0);
    cyc("a_wr",        1, 0, 1, INST_WRITE, 8'h90, 0, INST_START, 8'h00, 0, 2'b01, 1, INST_WRITE, 8'h90, 0, 0, 0);
    cyc("a_wr_cmp",    1, 0, 1, INST_WRITE, 8'h90, 0, INST_START, 8'h00, 1, 2'b01, 1, INST_WRITE, 8'h90, 1, 0, 0);
    cyc("a_stop",      1, 0, 1, INST_STOP,  8'h00, 0, INST_START, 8'h00, 0, 2'b01, 1, INST_STOP,  8'h00, 0, 0, 0);
    cyc("a_stop_cmp",  1, 0, 1, INST_STOP,  8'h00, 0, INST_START, 8'h00, 1, 2'b01, 1, INST_STOP,  8'h00, 1, 0, 0);
    cyc("a_rel_hold",  1, 0, 1, INST_STOP,  8'h00, 0, INST_START, 8'h00, 0, 2'b01, 0, 2'd0, 8'h00, 0, 0, 0);
    cyc("a_rel_drop",  1, 0, 0, INST_STOP,  8'h00, 0, INST_START, 8'h00, 0, 2'b01, 0, 2'd0, 8'h00, 0, 0, 0);
    cyc("a_free",      1, 0, 0, INST_START, 8'h00, 0, INST_START, 8'h00, 0, 2'b00, 0, 2'd0, 8'h00, 0, 0, 0);

    // Simultaneous requests after reset: req0 first, req1 within 2 cycles of the drop.
    cyc("b_rst",       1, 1, 0, INST_START, 8'h00, 0, INST_START, 8'h00, 0, 2'b00, 0, 2'd0, 8'h00, 0, 0, 0);
    cyc("b_both",      1, 0, 1, INST_START, 8'h11, 1, INST_START, 8'h22, 0, 2'b00, 0, 2'd0, 8'h00, 0, 0, 0);
    cyc("b_g0",        1, 0, 1, INST_START, 8'h11, 1, INST_START, 8'h22, 0, 2'b01, 1, INST_START, 8'h11, 0, 0, 0);
    cyc("b_stop0",     1, 0, 1, INST_STOP,  8'h11, 1, INST_START, 8'h22, 1, 2'b01, 1, INST_STOP,  8'h11, 1, 0, 0);
    cyc("b_drop0",     1, 0, 0, INST_STOP,  8'h11, 1, INST_START, 8'h22, 0, 2'b01, 0, 2'd0, 8'h00, 0, 0, 0);
    cyc("b_idle",      1, 0, 0, INST_START, 8'h00, 1, INST_START, 8'h22, 0, 2'b00, 0, 2'd0, 8'h00, 0, 0, 0);
    cyc("b_g1",        1, 0, 0, INST_START, 8'h00, 1, INST_START, 8'h22, 1, 2'b10, 1, INST_START, 8'h22, 0, 1, 0);
    cyc("b_stop1",     1, 0, 0, INST_START, 8'h00, 1, INST_STOP,  8'h00, 1, 2'b10, 1, INST_STOP,  8'h00, 0, 1, 0);
    cyc("b_drop1",     1, 0, 0, INST_START, 8'h00, 0, INST_STOP,  8'h00, 0, 2'b10, 0, 2'd0, 8'h00, 0, 0, 0);

    // Req1 requests in the middle of a req0 transaction: ignored until IDLE.
    cyc("c_req0",      1, 0, 1, INST_START, 8'h33, 0, INST_START, 8'h00, 0, 2'b00, 0, 2'd0, 8'h00, 0, 0, 0);
    cyc("c_wr0",       1, 0, 1, INST_WRITE, 8'h44, 1, INST_READ,  8'h55, 1, 2'b01, 1, INST_WRITE, 8'h44, 1, 0, 0);
    cyc("c_wr0b",      1, 0, 1, INST_WRITE, 8'h44, 1, INST_READ,  8'h55, 0, 2'b01, 1, INST_WRITE, 8'h44, 0, 0, 0);
    cyc("c_stop0",     1, 0, 1, INST_STOP,  8'h00, 1, INST_READ,  8'h55, 1, 2'b01, 1, INST_STOP,  8'h00, 1, 0, 0);
    cyc("c_drop0",     1, 0, 0, INST_STOP,  8'h00, 1, INST_READ,  8'h55, 0, 2'b01, 0, 2'd0, 8'h00, 0, 0, 0);
    cyc("c_idle",      1, 0, 0, INST_START, 8'h00, 1, INST_READ,  8'h55, 0, 2'b00, 0, 2'd0, 8'h00, 0, 0, 0);

    // Reset during a req1 READ; round-robin history must be back to "req0 first".
    cyc("d_rd1",       1, 0, 0, INST_START, 8'h00, 1, INST_READ,  8'h55, 0, 2'b10, 1, INST_READ,  8'h55, 0, 0, 0);
    cyc("d_rst",       1, 1, 0, INST_START, 8'h00, 1, INST_READ,  8'h55, 1, 2'b10, 1, INST_READ,  8'h55, 0, 1, 0);
    cyc("d_after_rst", 1, 0, 0, INST_START, 8'h00, 0, INST_READ,  8'h00, 0, 2'b00, 0, 2'd0, 8'h00, 0, 0, 0);
    cyc("d_both",      1, 0, 1, INST_START, 8'h66, 1, INST_START, 8'h77, 0, 2'b00, 0, 2'd0, 8'h00, 0, 0, 0);
    cyc("d_g0",        1, 0, 1, INST_START, 8'h66, 1, INST_START, 8'h77, 0, 2'b01, 1, INST_START, 8'h66, 0, 0, 0);
    cyc("d_stop0",     1, 0, 1, INST_STOP,  8'h66, 1, INST_START, 8'h77, 1, 2'b01, 1, INST_STOP,  8'h66, 1, 0, 0);
    cyc("d_drop0",     1, 0, 0, INST_STOP,  8'h66, 1, INST_START, 8'h77, 0, 2'b01, 0, 2'd0, 8'h00, 0, 0, 0);
    cyc("d_idle",      1, 0, 0, INST_START, 8'h00, 1, INST_START, 8'h77, 0, 2'b00, 0, 2'd0, 8'h00, 0, 0, 0);
    cyc("d_stop1",     1, 0, 0, INST_START, 8'h00, 1, INST_STOP,  8'h77, 1, 2'b10, 1, INST_STOP,  8'h77, 0, 1, 0);
    cyc("d_drop1",     1, 0, 0, INST_START, 8'h00, 0, INST_STOP,  8'h77, 0, 2'b10, 0, 2'd0, 8'h00, 0, 0, 0);
    cyc("d_free",      1, 0, 0, INST_START, 8'h00, 0, INST_START, 8'h00, 0, 2'b00, 0, 2'd0, 8'h00, 0, 0, 0);

    // Req1 takes the bus and the master never completes.
    cyc("e_req1",      1, 0, 0, INST_START, 8'h00, 1, INST_START, 8'h88, 0, 2'b00, 0, 2'd0, 8'h00, 0, 0, 0);
    for (int k = 0; k < int'(TbTimeout); k++) begin
      cyc("e_busy",    1, 0, 0, INST_START, 8'h00, 1, INST_START, 8'h88, 0, 2'b10, 1, INST_START, 8'h88, 0, 0, 0);
    end
`ifdef ADC_ARB_TIMEOUT_EN
    cyc("e_tmo",       1, 0, 1, INST_START, 8'h99, 1, INST_START, 8'h88, 0, 2'b00, 0, 2'd0, 8'h00, 0, 0, 1);
    cyc("e_g0",        1, 0, 1, INST_START, 8'h99, 1, INST_START, 8'h88, 0, 2'b01, 1, INST_START, 8'h99, 0, 0, 0);
`else
    cyc("e_hold",      1, 0, 1, INST_START, 8'h99, 1, INST_START, 8'h88, 0, 2'b10, 1, INST_START, 8'h88, 0, 0, 0);
    cyc("e_hold2",     1, 0, 1, INST_START, 8'h99, 1, INST_START, 8'h88, 0, 2'b10, 1, INST_START, 8'h88, 0, 0, 0);
`endif
    cyc("z_rst",       0, 1, 0, INST_START, 8'h00, 0, INST_START, 8'h00, 0, 2'b00, 0, 2'd0, 8'h00, 0, 0, 0);
    cyc("z_idle",      1, 0, 0, INST_START, 8'h00, 0, INST_START, 8'h00, 0, 2'b00, 0, 2'd0, 8'h00, 0, 0, 0);

    // Let the monitor drain the scoreboard, with a bound.
    for (int w = 0; w < 10 && sb_q.size() != 0; w++) begin
      @(negedge clk);
    end
    #1;
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_bus_arbiter.md
ADC_BUS_ARBITER -- requirements
Module: adc_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning max cycles a grant is held without a master complete before forced release.
REQ-002 SHALL have port clk_i  input  1  system clock (27 MHz); single clock domain.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports reqN_instruction_i  input  2, reqN_enable_i  input  1, reqN_byte_to_send_i  input  8 (N=0,1), meaning requester N's I2C command, strobe and write data.
REQ-005 SHALL have ports reqN_byte_received_o  output  8, reqN_complete_o  output  1 (N=0,1), meaning read data and completion returned to requester N.
REQ-006 SHALL have ports i2c_instruction_o  output  2, i2c_enable_o  output  1, i2c_byte_to_send_o  output  8, meaning the command to the shared I2C master.
REQ-007 SHALL have ports i2c_byte_received_i  input  8, i2c_complete_i  input  1, meaning the shared master's response.
REQ-008 SHALL have port grant_o  output  2  one-hot current owner (00 = bus free).
REQ-009 SHALL have port timeout_o  output  1  one-cycle pulse on forced release.

Function
REQ-010 SHALL implement states IDLE, BUSY, RELEASE in a registered FSM.
REQ-011 IDLE: if any reqN_enable_i is high, SHALL register the winner in grant_o and enter BUSY on the next edge; otherwise stay IDLE.
REQ-012 Simultaneous requests SHALL resolve round-robin: winner is the requester not granted last; after reset requester 0 wins first.
REQ-013 In BUSY, i2c_instruction_o, i2c_enable_o, i2c_byte_to_send_o SHALL be combinationally muxed from the granted requester; latency from reqN_enable_i rise (in IDLE) to i2c_enable_o rise is exactly 1 cycle.
REQ-014 Outside BUSY, i2c_enable_o SHALL be 0, i2c_instruction_o 0, i2c_byte_to_send_o 0.
REQ-015 reqN_complete_o SHALL equal i2c_complete_i gated by grant_o[N]; the non-granted requester SHALL see 0.
REQ-016 reqN_byte_received_o SHALL be broadcast i2c_byte_received_i to both requesters.
REQ-017 Grant SHALL persist across a whole transaction (START, WRITE/READ bytes); completion of non-STOP instructions SHALL keep BUSY.
REQ-018 When i2c_complete_i is high in BUSY with granted instruction == INST_STOP, SHALL enter RELEASE.
REQ-019 RELEASE: SHALL hold grant_o and i2c_enable_o=0 until the granted reqN_enable_i is low, then clear grant_o, record last owner, go IDLE; request from the other requester in the same cycle is served from IDLE on the following cycle.
REQ-020 A request from the non-granted requester during BUSY/RELEASE SHALL be ignored (not latched) until IDLE.

Reset
REQ-021 On rst_i high at a clock edge: state=IDLE, grant_o=00, last owner=1, timeout counter=0, timeout_o=0; mid-transaction reset SHALL drop i2c_enable_o at that edge without waiting for STOP.

Configuration
REQ-022 With ADC_ARB_TIMEOUT_EN defined: a counter SHALL run in BUSY, clear on each i2c_complete_i, and on reaching TIMEOUT_CYCLES force RELEASE-equivalent release to IDLE (owner recorded) and pulse timeout_o for 1 cycle.
REQ-023 Without ADC_ARB_TIMEOUT_EN: no counter is synthesized, timeout_o SHALL be tied 0, grant held indefinitely.

Structure
REQ-024 Package adc_bus_pkg SHALL hold INST_START=2'd0, INST_STOP=2'd1, INST_READ=2'd2, INST_WRITE=2'd3 and the state encoding; shared with the I2C master and adc users.
REQ-025 Round-robin select SHALL be a sub-module rr_pick2 (inputs 2 requests + last owner, output one-hot grant); FSM and muxes in the top of the block.

Verification
REQ-026 Req0 alone: START, WRITE 0x90, STOP -> grant_o=01 one cycle after enable, three req0 completes, grant_o=00 after enable drops.
REQ-027 Both enable same cycle after reset -> grant_o=01; after req0 STOP+drop, grant_o=10 within 2 cycles.
REQ-028 Req1 asserts mid req0 transaction -> i2c_byte_to_send_o always equals req0 data until req0 STOP; req1_complete_o stays 0.
REQ-029 rst_i pulsed during req1 READ -> next cycle grant_o=00, i2c_enable_o=0, state IDLE.
REQ-030 ADC_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, master never completes -> timeout_o pulse at cycle 16 of BUSY, grant_o=00, next request granted to other requester.
